remora_frame_ctrl: RTL and testbench
====================================

# remora_frame_ctrl

Command-frame controller between the SPI slave and the motion/IO datapath. It detects end-of-frame on the SPI select line and validates the frame header. Valid write-frame fields are latched into stable command registers that drive the stepgens, PWMs, joint enables and digital outputs. A watchdog forces all commands to a safe state when the host stops sending valid frames.

## Interface
- BUFFER_SIZE, 240: SPI frame width in bits; must equal 8*(4+4*JOINTS+2*VOUTS+2).
- JOINTS, 5: number of stepgen frequency commands (1..8).
- VOUTS, 2: number of 16-bit PWM setpoints.
- DOUTS, 6: number of digital outputs (1..8).
- TIMEOUT_CYCLES, 2400000: watchdog period in clk cycles (50 ms at 48 MHz); must be ≥2.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ssel  in  1  raw SPI_SSEL pin, asynchronous, active-low frame.
- rx_data  in  BUFFER_SIZE  received frame from SPI slave, byte 0 in bits [BUFFER_SIZE-1 -: 8].
- freq_cmd  out  32*JOINTS  signed frequency commands, joint j in [32j+31:32j].
- set_point  out  16*VOUTS  PWM duty, channel v in [16v+15:16v].
- joint_en  out  JOINTS  joint enables.
- dout  out  DOUTS  digital outputs.
- wd_tripped  out  1  watchdog expired since the last valid write frame.
- frame_ok_cnt  out  16  count of valid frames (read or write).
- frame_err_cnt  out  16  count of frames with an unknown header.

## Operation
- Frame byte layout, little-endian per field: bytes 0-3 header; bytes 4+4j..7+4j joint j; then VOUTS 16-bit setpoints; then enable byte (bit 7 = joint 0, descending); then dout byte (bit 0 = DOUT0).
- Header 0x77726974 ("writ") = WRITE; 0x72656164 ("read") = READ; any other value = ERROR.
- ssel passes through a 2-FF synchronizer; a registered rising edge (0→1) marks end of frame.
- FSM states:
  - IDLE: on edge, snapshot rx_data into the capture register and go to CHECK.
  - CHECK: decode header. WRITE → LATCH. READ → increment frame_ok_cnt, restart watchdog, go to IDLE. ERROR → increment frame_err_cnt, go to IDLE.
  - LATCH: load all command outputs from the capture, clear wd_tripped, restart watchdog, increment frame_ok_cnt, go to IDLE.
- Edges arriving outside IDLE are dropped; the host frame period is far longer than 2 cycles.
- Watchdog: down-counter loaded with TIMEOUT_CYCLES-1 on restart. On reaching 0 it sets wd_tripped and zeroes freq_cmd, set_point, joint_en and dout. It then holds at 0 until the next restart.
- Counters are 16-bit and wrap (0xFFFF+1 → 0).
- Reset values: every output 0; FSM in IDLE; synchronizer flops 1; watchdog loaded with TIMEOUT_CYCLES-1.

## Timing
- Cycle S: first cycle ssel_sync = 1. Edge is registered at S.
- S+1: CHECK.
- S+2: LATCH; new outputs and cleared wd_tripped are visible from S+3.
- ssel pin rise to output update is 4–5 clk cycles, depending on synchronizer phase.
- rx_data must be stable from the ssel rise through cycle S. The snapshot decouples outputs from later rx_data changes.
- Watchdog expiry and LATCH in the same cycle: LATCH wins. Outputs take the new values, wd_tripped stays 0, and the counter reloads.
- Expiry in the same cycle as a READ restart: the restart wins and there is no trip.
- rst_n asserted mid-FSM: immediate return to reset values. No partial latch is ever visible.

## Configuration
- REMORA_FRAME_WATCHDOG_EN defined: watchdog behaves as described above.
- REMORA_FRAME_WATCHDOG_EN undefined: no watchdog counter. wd_tripped is tied to 0, and commands hold their last latched values indefinitely. FSM and counters are unchanged.

## Test plan
- Reset with rst_n=0 then release → all outputs 0, wd_tripped=0, counters 0.
- WRITE frame with joint0=0x00001000, setpoint0=0x8000, enable byte 0xF8, dout byte 0x15, then ssel rise → freq_cmd[31:0]=0x00001000, set_point[15:0]=0x8000, joint_en=5'b11111, dout=6'b010101 at S+3; frame_ok_cnt=1.
- Header 0xDEADBEEF frame → outputs unchanged, frame_err_cnt +1.
- READ frame → outputs unchanged, frame_ok_cnt +1, watchdog restarted.
- With REMORA_FRAME_WATCHDOG_EN, TIMEOUT_CYCLES=100 and no frames after a WRITE → at 100 cycles wd_tripped=1 and all commands 0. The next WRITE restores values and clears wd_tripped.
- Two edges 1 cycle apart, and rst_n pulsed during CHECK → second edge ignored; reset gives all outputs 0 with no latch.

Source files
------------

// File: rtl/remora_frame_ctrl.sv
// remora_frame_ctrl: detects SPI end-of-frame, validates the header and latches command fields.
// Host watchdog is built only when REMORA_FRAME_WATCHDOG_EN is defined.
module remora_frame_ctrl #(
    parameter int BUFFER_SIZE    = 240,
    parameter int JOINTS         = 5,
    parameter int VOUTS          = 2,
    parameter int DOUTS          = 6,
    parameter int TIMEOUT_CYCLES = 2400000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ssel,
    input  logic [BUFFER_SIZE-1:0] rx_data,
    output logic [32*JOINTS-1:0]   freq_cmd,
    output logic [16*VOUTS-1:0]    set_point,
    output logic [JOINTS-1:0]      joint_en,
    output logic [DOUTS-1:0]       dout,
    output logic                   wd_tripped,
    output logic [15:0]            frame_ok_cnt,
    output logic [15:0]            frame_err_cnt
);

    localparam logic [31:0] HDR_WRITE = 32'h7772_6974;
    localparam logic [31:0] HDR_READ  = 32'h7265_6164;
    localparam int          EN_IDX    = 4 + 4*JOINTS + 2*VOUTS;
    localparam int          DOUT_IDX  = EN_IDX + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    logic                   r_ssel_s1, r_ssel_s2, r_ssel_d;
    logic [1:0]             r_state;
    logic [BUFFER_SIZE-1:0] r_cap;
    logic [15:0]            r_ok_cnt, r_err_cnt;
    logic [32*JOINTS-1:0]   r_freq;
    logic [16*VOUTS-1:0]    r_sp;
    logic [JOINTS-1:0]      r_en;
    logic [DOUTS-1:0]       r_dout;

    logic                   w_edge;
    logic [31:0]            w_hdr;
    logic [32*JOINTS-1:0]   w_freq_new;
    logic [16*VOUTS-1:0]    w_sp_new;
    logic [JOINTS-1:0]      w_en_new;
    logic [DOUTS-1:0]       w_dout_new;
    logic [7:0]             w_en_byte, w_dout_byte;
    logic                   w_wd_expire;
    logic                   w_unused;

    // Synchronizer resets high so a released reset never looks like end-of-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ssel_s1 <= 1'b1;
            r_ssel_s2 <= 1'b1;
            r_ssel_d  <= 1'b1;
        end else begin
            r_ssel_s1 <= ssel;
            r_ssel_s2 <= r_ssel_s1;
            r_ssel_d  <= r_ssel_s2;
        end
    end

    assign w_edge = r_ssel_s2 & ~r_ssel_d;

    // Byte k of the frame sits at [BUFFER_SIZE-1-8k -: 8]; multi-byte fields are little-endian.
    for (genvar b = 0; b < 4; b++) begin : g_hdr
        assign w_hdr[8*b +: 8] = r_cap[BUFFER_SIZE-1-8*b -: 8];
    end

    for (genvar j = 0; j < JOINTS; j++) begin : g_joint
        for (genvar b = 0; b < 4; b++) begin : g_byte
            assign w_freq_new[32*j+8*b +: 8] = r_cap[BUFFER_SIZE-1-8*(4+4*j+b) -: 8];
        end
        assign w_en_new[j] = w_en_byte[7-j];
    end

    for (genvar v = 0; v < VOUTS; v++) begin : g_vout
        for (genvar b = 0; b < 2; b++) begin : g_byte
            assign w_sp_new[16*v+8*b +: 8] = r_cap[BUFFER_SIZE-1-8*(4+4*JOINTS+2*v+b) -: 8];
        end
    end

    assign w_en_byte   = r_cap[BUFFER_SIZE-1-8*EN_IDX -: 8];
    assign w_dout_byte = r_cap[BUFFER_SIZE-1-8*DOUT_IDX -: 8];
    assign w_dout_new  = w_dout_byte[DOUTS-1:0];
    assign w_unused    = ^{w_en_byte, w_dout_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cap     <= '0;
            r_ok_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_cap   <= rx_data;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_hdr == HDR_WRITE) begin
                        r_state <= ST_LATCH;
                    end else begin
                        r_state <= ST_IDLE;
                        if (w_hdr == HDR_READ) r_ok_cnt  <= r_ok_cnt + 16'd1;
                        else                   r_err_cnt <= r_err_cnt + 16'd1;
                    end
                end
                ST_LATCH: begin
                    r_ok_cnt <= r_ok_cnt + 16'd1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A LATCH always restarts the watchdog, so it can never coincide with an expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_freq <= '0;
            r_sp   <= '0;
            r_en   <= '0;
            r_dout <= '0;
        end else if (r_state == ST_LATCH) begin
            r_freq <= w_freq_new;
            r_sp   <= w_sp_new;
            r_en   <= w_en_new;
            r_dout <= w_dout_new;
        end else if (w_wd_expire) begin
            r_freq <= '0;
            r_sp   <= '0;
            r_en   <= '0;
            r_dout <= '0;
        end
    end

`ifdef REMORA_FRAME_WATCHDOG_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_wd_tripped;
    logic            w_wd_restart;

    assign w_wd_restart = (r_state == ST_LATCH) || ((r_state == ST_CHECK) && (w_hdr == HDR_READ));
    assign w_wd_expire  = (r_wd_cnt == WD_ONE) && !w_wd_restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt     <= WD_LOAD;
            r_wd_tripped <= 1'b0;
        end else begin
            if (w_wd_restart)        r_wd_cnt <= WD_LOAD;
            else if (r_wd_cnt != '0) r_wd_cnt <= r_wd_cnt - WD_ONE;

            if (r_state == ST_LATCH) r_wd_tripped <= 1'b0;
            else if (w_wd_expire)    r_wd_tripped <= 1'b1;
        end
    end

    assign wd_tripped = r_wd_tripped;
`else
    assign w_wd_expire = 1'b0;
    assign wd_tripped  = 1'b0;
`endif

    assign freq_cmd      = r_freq;
    assign set_point     = r_sp;
    assign joint_en      = r_en;
    assign dout          = r_dout;
    assign frame_ok_cnt  = r_ok_cnt;
    assign frame_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_remora_frame_ctrl.sv
// Bench for remora_frame_ctrl: directed frames, expected responses queued and checked by a monitor.
// Watchdog expectations follow REMORA_FRAME_WATCHDOG_EN.
module tb_remora_frame_ctrl;

    localparam int BS = 240;
    localparam int J  = 5;
    localparam int V  = 2;
    localparam int D  = 6;
    localparam int TO = 100;

    localparam logic [31:0] HDR_W   = 32'h7772_6974;
    localparam logic [31:0] HDR_R   = 32'h7265_6164;
    localparam logic [31:0] HDR_BAD = 32'hDEAD_BEEF;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ssel  = 1'b1;
    logic [BS-1:0] rx_data = '0;
    logic [32*J-1:0] freq_cmd;
    logic [16*V-1:0] set_point;
    logic [J-1:0]    joint_en;
    logic [D-1:0]    dout;
    logic            wd_tripped;
    logic [15:0]     frame_ok_cnt, frame_err_cnt;

    remora_frame_ctrl #(
        .BUFFER_SIZE(BS), .JOINTS(J), .VOUTS(V), .DOUTS(D), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ssel(ssel), .rx_data(rx_data),
        .freq_cmd(freq_cmd), .set_point(set_point), .joint_en(joint_en), .dout(dout),
        .wd_tripped(wd_tripped), .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: got time limit, required test end");
        $fatal(1, "time limit");
    end

    // scoreboard
    typedef struct {
        logic [32*J-1:0] freq;
        logic [16*V-1:0] sp;
        logic [J-1:0]    en;
        logic [D-1:0]    dout;
        logic            wd;
        logic [15:0]     ok;
        logic [15:0]     err;
        int              lat_min;
        int              lat_max;
        int              rise_cyc;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    logic [32*J-1:0] m_freq = '0;
    logic [16*V-1:0] m_sp   = '0;
    logic [J-1:0]    m_en   = '0;
    logic [D-1:0]    m_dout = '0;
    logic            m_wd   = 1'b0;
    logic [15:0]     m_ok   = '0;
    logic [15:0]     m_err  = '0;
    int              last_rise = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_freq"}, 256'(freq_cmd),   256'(m_freq));
        check({tag, "_sp"},   256'(set_point),  256'(m_sp));
        check({tag, "_en"},   256'(joint_en),   256'(m_en));
        check({tag, "_dout"}, 256'(dout),       256'(m_dout));
        check({tag, "_wd"},   256'(wd_tripped), 256'(m_wd));
    endtask

    // Frame bytes are listed in wire order and shifted in so byte 0 ends up at the top.
    function automatic logic [BS-1:0] build_frame(input logic [31:0] hdr, input logic [32*J-1:0] jv,
                                                  input logic [16*V-1:0] spv, input logic [7:0] enb,
                                                  input logic [7:0] db);
        logic [7:0]    bytes [BS/8];
        logic [BS-1:0] f;
        int            k;
        k = 0;
        for (int b = 0; b < 4; b++) begin bytes[k] = hdr[8*b +: 8]; k++; end
        for (int j = 0; j < J; j++)
            for (int b = 0; b < 4; b++) begin bytes[k] = jv[32*j+8*b +: 8]; k++; end
        for (int v = 0; v < V; v++)
            for (int b = 0; b < 2; b++) begin bytes[k] = spv[16*v+8*b +: 8]; k++; end
        bytes[k] = enb; k++;
        bytes[k] = db;
        f = '0;
        for (int i = 0; i < BS/8; i++) f = {f[BS-9:0], bytes[i]};
        return f;
    endfunction

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_pending", 256'(exp_q.size()), 256'(0));
        exp_q.delete();
    endtask

    // driver: ssel low, frame presented, ssel rise; rx_data scrambled after the capture point
    task automatic send_frame(input logic [31:0] hdr, input logic [32*J-1:0] jv, input logic [16*V-1:0] spv,
                              input logic [7:0] enb, input logic [7:0] db,
                              input logic [J-1:0] x_en, input logic [D-1:0] x_dout, input bit dbl);
        exp_t e;
        @(posedge clk); #1;
        ssel    = 1'b0;
        rx_data = build_frame(hdr, jv, spv, enb, db);
        repeat (4) @(posedge clk);
        #1;
        if (hdr == HDR_W) begin
            m_freq = jv; m_sp = spv; m_en = x_en; m_dout = x_dout; m_wd = 1'b0;
            m_ok++;
            e.lat_min = 4; e.lat_max = 5;
        end else if (hdr == HDR_R) begin
            m_ok++;
            e.lat_min = 3; e.lat_max = 4;
        end else begin
            m_err++;
            e.lat_min = 3; e.lat_max = 4;
        end
        e.freq = m_freq; e.sp = m_sp; e.en = m_en; e.dout = m_dout; e.wd = m_wd;
        e.ok = m_ok; e.err = m_err; e.rise_cyc = cyc;
        last_rise = cyc;
        exp_q.push_back(e);
        ssel = 1'b1;
        if (dbl) begin
            @(posedge clk); #1 ssel = 1'b0;
            @(posedge clk); #1 ssel = 1'b1;
            @(posedge clk); #1 rx_data = build_frame(HDR_R, '0, '0, 8'h00, 8'h00);
        end else begin
            repeat (4) @(posedge clk);
            #1;
            for (int k = 0; k < BS/16; k++) rx_data[16*k +: 16] = 16'($urandom_range(0, 65535));
        end
        repeat (8) @(posedge clk);
        wait_drain();
    endtask

    // monitor: a counter change is the DUT's per-frame response
    initial begin
        logic [15:0] p_ok, p_err;
        exp_t        e;
        int          lat;
        p_ok  = '0;
        p_err = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_ok  = '0;
                p_err = '0;
            end else if (frame_ok_cnt !== p_ok || frame_err_cnt !== p_err) begin
                p_ok  = frame_ok_cnt;
                p_err = frame_err_cnt;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got ok=%0d err=%0d, required no response", p_ok, p_err);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_freq", 256'(freq_cmd),      256'(e.freq));
                    check("rsp_sp",   256'(set_point),     256'(e.sp));
                    check("rsp_en",   256'(joint_en),      256'(e.en));
                    check("rsp_dout", 256'(dout),          256'(e.dout));
                    check("rsp_wd",   256'(wd_tripped),    256'(e.wd));
                    check("rsp_ok",   256'(frame_ok_cnt),  256'(e.ok));
                    check("rsp_err",  256'(frame_err_cnt), 256'(e.err));
                    lat = cyc - e.rise_cyc;
                    total++;
                    if (lat < e.lat_min || lat > e.lat_max) begin
                        bad++;
                        $display("FAIL latency: got %0d cycles, required %0d..%0d", lat, e.lat_min, e.lat_max);
                    end
                end
            end
        end
    end

    // directed sequence
    initial begin
        int target;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outputs("reset");
        check("reset_ok",  256'(frame_ok_cnt),  256'(0));
        check("reset_err", 256'(frame_err_cnt), 256'(0));

        // V1: joint0 0x1000, setpoint0 0x8000, enables 0xF8, douts 0x15
        send_frame(HDR_W, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_1000}, {16'h0000, 16'h8000},
                   8'hF8, 8'h15, 5'b11111, 6'b010101, 1'b0);
        // bad header carrying other payload: nothing latched, error count only
        send_frame(HDR_BAD, {32'h1, 32'h2, 32'h3, 32'h4, 32'h5}, {16'h1111, 16'h2222},
                   8'h00, 8'h00, 5'b00000, 6'b000000, 1'b0);
        // read frame: nothing latched, ok count advances
        send_frame(HDR_R, {32'h9, 32'h8, 32'h7, 32'h6, 32'h5}, {16'h3333, 16'h4444},
                   8'hFF, 8'hFF, 5'b00000, 6'b000000, 1'b0);
        // V2: extreme joint values, enables 0xA0 -> joints 0 and 2, douts 0xEA
        send_frame(HDR_W, {32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_F000, 32'h1234_5678},
                   {16'hFFFF, 16'h0001}, 8'hA0, 8'hEA, 5'b00101, 6'b101010, 1'b0);

        // silence after a write
        target = last_rise + 95;
        while (cyc < target) @(negedge clk);
        check_outputs("wd_before");
        target = last_rise + 106;
        while (cyc < target) @(negedge clk);
`ifdef REMORA_FRAME_WATCHDOG_EN
        m_freq = '0; m_sp = '0; m_en = '0; m_dout = '0; m_wd = 1'b1;
`endif
        check_outputs("wd_after");

        // V3 restores commands; enables 0x48 -> joints 1 and 4
        send_frame(HDR_W, {32'hCAFE_F00D, 32'h0, 32'h0, 32'h0102_0304, 32'hAAAA_5555},
                   {16'hABCD, 16'h1234}, 8'h48, 8'h3F, 5'b10010, 6'b111111, 1'b0);
        // V4 with a second ssel edge while the first frame is still being processed
        send_frame(HDR_W, {32'h5555_5555, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                   {16'h0F0F, 16'hF0F0}, 8'h08, 8'h01, 5'b10000, 6'b000001, 1'b1);

        // reset while the next write frame is in CHECK
        @(posedge clk); #1;
        ssel    = 1'b0;
        rx_data = build_frame(HDR_W, {5{32'h7777_7777}}, {2{16'h7777}}, 8'hFF, 8'hFF);
        repeat (4) @(posedge clk);
        #1 ssel = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        m_freq = '0; m_sp = '0; m_en = '0; m_dout = '0; m_wd = 1'b0; m_ok = '0; m_err = '0;
        repeat (10) @(negedge clk);
        check_outputs("midreset");
        check("midreset_ok",  256'(frame_ok_cnt),  256'(0));
        check("midreset_err", 256'(frame_err_cnt), 256'(0));

        // recovery after reset
        send_frame(HDR_W, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_1000}, {16'h0000, 16'h8000},
                   8'hF8, 8'h15, 5'b11111, 6'b010101, 1'b0);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
